// File: rtl/parity_check_receiver.sv
// Serial frame receiver: start bit, 8 data bits LSB first, one parity bit, one stop bit.
// One bit is taken per bit_en strobe; completed frames are reported with a one-cycle data_valid.
module parity_check_receiver #(
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial_in,
  input  logic       bit_en,
  input  logic       clear_err,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       frame_error,
  output logic [7:0] err_count,
  output logic       busy,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  localparam logic ODD = (PARITY_ODD != 0);

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic       mismatch;
  logic       frame_done;
  logic       frame_bad;

  // Stop bit is being sampled on this edge; the frame is bad on parity or framing error.
  assign frame_done = bit_en && (state == S_STOP);
  assign frame_bad  = mismatch || !serial_in;

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      bit_cnt      <= 3'd0;
      shift_reg    <= 8'h00;
      mismatch     <= 1'b0;
      data_out     <= 8'h00;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      err_count    <= 8'h00;
    end else begin
      data_valid <= 1'b0;
      if (bit_en) begin
        case (state)
          S_IDLE: begin
            if (!serial_in) begin
              state   <= S_DATA;
              bit_cnt <= 3'd0;
            end
          end
          S_DATA: begin
            shift_reg[bit_cnt] <= serial_in;
            bit_cnt            <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            mismatch <= serial_in ^ (^shift_reg) ^ ODD;
            state    <= S_STOP;
          end
          S_STOP: begin
            data_out     <= shift_reg;
            parity_error <= mismatch;
            frame_error  <= !serial_in;
            data_valid   <= 1'b1;
            state        <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end

      // A clear on the same edge as an error increment wins.
      if (clear_err) begin
        err_count <= 8'h00;
      end else if (frame_done && frame_bad && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: doc/parity_check_receiver.md
PARITY_CHECK_RECEIVER -- requirements
Module: parity_check_receiver

Interface
REQ-001 Parameter PARITY_ODD, default 0: 0 = even parity (expected parity bit = XOR of the 8 data bits); 1 = odd parity (expected = inverted XOR).
REQ-002 Port clk  input  1  the only clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port serial_in  input  1  serial line; idle level 1.
REQ-005 Port bit_en  input  1  bit strobe; serial_in SHALL be sampled only on edges where bit_en=1.
REQ-006 Port clear_err  input  1  synchronous clear of err_count.
REQ-007 Port data_out  output  8  last received data byte.
REQ-008 Port data_valid  output  1  one-cycle pulse marking a completed frame.
REQ-009 Port parity_error  output  1  parity mismatch flag for the last completed frame.
REQ-010 Port frame_error  output  1  stop-bit-0 flag for the last completed frame.
REQ-011 Port err_count  output  8  saturating count of frames with any error.
REQ-012 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 Frame format SHALL be: start bit 0, 8 data bits LSB first, 1 parity bit, stop bit 1; one bit per bit_en strobe.
REQ-014 FSM SHALL have states IDLE, DATA, PARITY, STOP; with bit_en=0 the FSM, bit counter and shift register SHALL hold.
REQ-015 IDLE: bit_en=1 with serial_in=0 -> DATA, bit counter cleared to 0; serial_in=1 -> remain IDLE.
REQ-016 DATA: each strobe stores serial_in into shift register bit [counter], counter increments; strobe storing bit 7 -> PARITY.
REQ-017 PARITY: strobe captures the parity bit and computes mismatch against the PARITY_ODD rule -> STOP.
REQ-018 STOP: strobe SHALL, on that same edge, load data_out, parity_error (mismatch), frame_error (serial_in==0), set data_valid, and return to IDLE.
REQ-019 data_valid SHALL be high for exactly one clk cycle following the stop-bit edge, even if bit_en stays high.
REQ-020 data_out, parity_error, frame_error SHALL hold their values until the next frame completes; they SHALL NOT change mid-frame.
REQ-021 Parity SHALL be checked and reported even when frame_error=1; data_out SHALL be loaded in both cases.
REQ-022 A 0 sampled as the stop bit SHALL NOT be taken as a start bit; a new frame requires a later strobe with serial_in=0 while in IDLE.
REQ-023 Latency: data_valid rises one clk edge after... i.e. registered on the edge sampling the stop bit; no additional pipeline stage.
REQ-024 err_count SHALL increment by exactly 1 at frame completion when parity_error or frame_error (or both) is set, and saturate at 255.
REQ-025 clear_err=1 SHALL zero err_count on the next edge; clear coinciding with an increment SHALL yield 0.
REQ-026 busy SHALL be 0 in IDLE and 1 in DATA, PARITY, STOP.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, counter 0, shift register 0, data_out=0x00, data_valid=0, parity_error=0, frame_error=0, err_count=0, busy=0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; no data_valid SHALL be produced for it after release.
REQ-029 After rst_n deasserts, the first edge SHALL behave as in IDLE.

Verification
REQ-030 Even parity, frames 0x00/p0, 0x01/p1, 0x03/p0, 0xAA/p0, 0xFF/p0, stop 1 -> each data_out matches, data_valid one cycle, parity_error=0, frame_error=0, err_count=0.
REQ-031 Frame 0x01 with parity 0, stop 1 -> data_out=0x01, parity_error=1, frame_error=0, err_count=1; PARITY_ODD=1 instance with same frame -> parity_error=0.
REQ-032 Frame 0xAA/p0 with stop 0 -> data_out=0xAA, frame_error=1, parity_error=0, err_count+1; next strobe with serial_in=1 leaves busy=0.
REQ-033 bit_en gapped randomly (1 in 4 cycles) on frame 0x5A/p0 -> identical result to continuous strobing; data_valid still exactly one cycle.
REQ-034 256 consecutive parity-error frames -> err_count=255 (saturated); clear_err pulse coinciding with a 257th error frame -> err_count=0.
REQ-035 rst_n pulsed low after 4 data bits of frame 0xFF -> all outputs 0 immediately; no data_valid until a complete new frame 0x03/p0 is received.
